rfid_packet_assembler: RTL and testbench
========================================

# rfid_packet_assembler

Front-end framing stage for the RFID tag command path. It collects the serial, already-demodulated command bits of one reader frame into a left-justified 128-bit word and classifies the command-code width from the leading bits. It then presents the word, the code-width class and a `packet_rdy` strobe to the downstream command decoder, which captures on the falling edge of `packet_rdy`.

## Interface
- `RDY_CYCLES`, default 2: number of cycles `packet_rdy` stays high per frame, minimum 1.
- `MAX_BITS`, default 128: frame capacity in bits; equals the `packet_data` width.
- `clock`  in  1: single system clock, rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `frame_start`  in  1: one-cycle delimiter pulse marking the start of a new frame.
- `bit_valid`  in  1: `bit_data` carries one frame bit this cycle.
- `bit_data`  in  1: demodulated bit value, first-transmitted bit first.
- `frame_end`  in  1: one-cycle end-of-frame pulse.
- `packet_data`  out  128: frame bits, left-justified; the first bit is at [127] and unused LSBs are 0.
- `op_code`  out  2: command-width class. 0 = 2-bit code, 1 = 4-bit code, 2 = 8-bit code, 3 = invalid.
- `packet_len`  out  8: number of bits in the held frame, 0..128.
- `packet_rdy`  out  1: presentation strobe; high for `RDY_CYCLES` cycles.
- `frame_error`  out  1: one-cycle pulse when a frame is discarded.

## Operation
- Reset values: every output is 0 and the state is IDLE.
- **IDLE**
  - `frame_start` clears the shift data, the count and the overflow flag, then goes to RECEIVE.
  - `bit_valid` and `frame_end` are ignored.
  - `packet_data`, `op_code` and `packet_len` keep the last presented frame.
- **RECEIVE**
  - On `bit_valid`, write `bit_data` to `packet_data[127-count]` and increment `count`.
  - When `count` is already 128, drop the bit and set the sticky `overflow` flag.
- **Classification**, fixed once 2 bits have arrived:
  - First bit 0 gives class 0.
  - First bits 10 give class 1.
  - First bits 11 give class 2.
  - Minimum length for classes 0, 1 and 2 is 2, 4 and 8 bits respectively.
- **`frame_end` in RECEIVE**
  - If `overflow` is set, or `count` is below the class minimum (including `count` below 2): pulse `frame_error`, return to IDLE, keep `packet_rdy` low, and set `op_code` to 3.
  - Otherwise: drive `op_code` with the class, `packet_len` with `count`, and `packet_rdy` high, then go to PRESENT.
- **`frame_start` in RECEIVE**: the partial frame is discarded without `frame_error` and reception restarts; the state stays RECEIVE.
- **PRESENT**
  - `packet_rdy` stays high for `RDY_CYCLES` cycles using a down-counter, then drops to 0 and the state returns to IDLE.
  - `frame_start`, `bit_valid` and `frame_end` are ignored.
- **Simultaneous events**
  - `frame_start` with `bit_valid` in the same cycle: the bit becomes bit 0 of the new frame.
  - `bit_valid` with `frame_end` in the same cycle: the bit is included before the length check.
- **Reset mid-frame or mid-PRESENT**: everything returns to reset values immediately; no `frame_error` is produced.

## Timing
- `frame_end` is sampled at edge T. `packet_rdy`, `op_code`, `packet_len` and the final `packet_data` are all valid after edge T.
- `packet_rdy` falls after edge T+`RDY_CYCLES`.
- `packet_data`, `op_code` and `packet_len` stay stable from edge T until the edge at which a later `frame_start` is accepted in IDLE. This guarantees the decoder samples stable data on the cycle it sees `packet_rdy` low.
- The earliest accepted next `frame_start` is at edge T+`RDY_CYCLES`+1.
- `frame_error` is high for exactly the cycle after the `frame_end` edge.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `rfid_pkg`:
  - op_code constants `OPC_CMD2`=0, `OPC_CMD4`=1, `OPC_CMD8`=2, `OPC_INVALID`=3.
  - Class minimum lengths.
  - State encoding IDLE/RECEIVE/PRESENT.
- No sub-module. There is one FSM plus an index counter and an RDY down-counter; classification is a small local function.

## Test plan
- QueryRep, bits 0001 then `frame_end`: `packet_data[127:124]`=0001, rest 0, `op_code`=0, `packet_len`=4, `packet_rdy` high exactly 2 cycles, data held after the fall.
- Query, 22 bits 1000000000000000010000: `op_code`=1, `packet_len`=22, `packet_data[127:106]` matches the stream.
- NAK, 11000000: `op_code`=2, `packet_len`=8. Also check that `frame_start` during PRESENT is ignored.
- Runt frames, 1 bit, and also 110 (class 2 with 3 bits): `frame_error` pulses, `packet_rdy` never rises, `op_code`=3.
- 130 bits then `frame_end`: overflow gives `frame_error`, no `packet_rdy`. A following valid 8-bit frame is presented normally.
- `reset_n` low after 5 bits: outputs are 0 immediately. The next full frame after reset is presented with `packet_len` counting from 0.

Source files
------------

// File: rtl/rfid_pkg.sv
// ----------------------------------------------------------------------------
// rfid_pkg
//   Shared definitions for the RFID tag command path: command-width class
//   codes reported on op_code, the minimum frame length of each class, and
//   the state encoding of the packet assembler FSM.
// ----------------------------------------------------------------------------
package rfid_pkg;

   // Command-width classes as seen by the downstream command decoder.
   localparam logic [1:0] OPC_CMD2    = 2'd0;
   localparam logic [1:0] OPC_CMD4    = 2'd1;
   localparam logic [1:0] OPC_CMD8    = 2'd2;
   localparam logic [1:0] OPC_INVALID = 2'd3;

   // Number of leading bits needed before the class is known.
   localparam logic [7:0] CLASS_BITS = 8'd2;

   // Shortest legal frame for each class.
   localparam logic [7:0] MIN_LEN_CMD2 = 8'd2;
   localparam logic [7:0] MIN_LEN_CMD4 = 8'd4;
   localparam logic [7:0] MIN_LEN_CMD8 = 8'd8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECEIVE = 2'd1,
      ST_PRESENT = 2'd2
   } state_t;

   // Minimum frame length of a class; the invalid class can never be met.
   function automatic logic [7:0] class_min_len(input logic [1:0] opc);
      logic [7:0] len;
      case (opc)
         OPC_CMD2: len = MIN_LEN_CMD2;
         OPC_CMD4: len = MIN_LEN_CMD4;
         OPC_CMD8: len = MIN_LEN_CMD8;
         default:  len = 8'hFF;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/rfid_packet_assembler.sv
// ----------------------------------------------------------------------------
// rfid_packet_assembler
//   Collects the demodulated command bits of one reader frame into a
//   left-justified word, classifies the command-code width from the leading
//   bits and presents the frame to the command decoder with a packet_rdy
//   strobe. The decoder captures on the falling edge of packet_rdy, so the
//   presented word stays frozen until the next frame_start is taken in IDLE.
//
// Parameters
//   RDY_CYCLES  cycles packet_rdy stays high per frame (>= 1)
//   MAX_BITS    frame capacity in bits, width of packet_data (<= 255)
//
// Ports
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   frame_start  one-cycle start-of-frame delimiter
//   bit_valid    bit_data carries a frame bit this cycle
//   bit_data     demodulated bit, first-transmitted bit first
//   frame_end    one-cycle end-of-frame pulse
//   packet_data  frame bits, first bit at the MSB, unused LSBs zero
//   op_code      command-width class (rfid_pkg OPC_*)
//   packet_len   number of bits in the held frame
//   packet_rdy   presentation strobe, RDY_CYCLES cycles long
//   frame_error  one-cycle pulse when a frame is discarded
// ----------------------------------------------------------------------------
module rfid_packet_assembler
   import rfid_pkg::*;
#(
   parameter int RDY_CYCLES = 2,
   parameter int MAX_BITS   = 128
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                frame_start,
   input  logic                bit_valid,
   input  logic                bit_data,
   input  logic                frame_end,
   output logic [MAX_BITS-1:0] packet_data,
   output logic [1:0]          op_code,
   output logic [7:0]          packet_len,
   output logic                packet_rdy,
   output logic                frame_error
);

   localparam int                 RDY_W    = (RDY_CYCLES > 1) ? $clog2(RDY_CYCLES) : 1;
   localparam logic [RDY_W-1:0]   RDY_LOAD = RDY_W'(RDY_CYCLES - 1);
   localparam logic [7:0]         CAPACITY = 8'(MAX_BITS);
   localparam logic [MAX_BITS-1:0] TOP_BIT = {1'b1, {(MAX_BITS-1){1'b0}}};

   // Class from the first two received bits: 0x -> 2-bit, 10 -> 4-bit,
   // 11 -> 8-bit command code.
   function automatic logic [1:0] classify(input logic first_bit, input logic second_bit);
      logic [1:0] opc;
      if (!first_bit)      opc = OPC_CMD2;
      else if (!second_bit) opc = OPC_CMD4;
      else                 opc = OPC_CMD8;
      return opc;
   endfunction

   state_t               state_q, state_d;
   logic [7:0]           count_q, count_d;
   logic                 overflow_q, overflow_d;
   logic [RDY_W-1:0]     rdy_cnt_q, rdy_cnt_d;
   logic [MAX_BITS-1:0]  data_d;
   logic [1:0]           op_d;
   logic [7:0]           len_d;
   logic                 rdy_d;
   logic                 err_d;

   // Frame contents after this cycle's bit has been accepted. A frame_start
   // clears the frame first so a coincident bit lands at position 0.
   logic [MAX_BITS-1:0]  acc_data;
   logic [7:0]           acc_count;
   logic                 acc_overflow;
   logic [1:0]           acc_class;

   always_comb begin
      // NOTE: every combinational output is given a default before any
      // branch; a path that leaves one unassigned would infer a latch.
      acc_data     = frame_start ? '0 : packet_data;
      acc_count    = frame_start ? 8'd0 : count_q;
      acc_overflow = frame_start ? 1'b0 : overflow_q;
      acc_class    = OPC_INVALID;

      if (bit_valid) begin
         if (acc_count == CAPACITY) begin
            acc_overflow = 1'b1;
         end else begin
            if (bit_data) acc_data = acc_data | (TOP_BIT >> acc_count);
            acc_count = acc_count + 8'd1;
         end
      end
      acc_class = classify(acc_data[MAX_BITS-1], acc_data[MAX_BITS-2]);
   end

   // NOTE: the FSM computes the next value of every register here, outputs
   // included, so all outputs come straight from flops with no input-to-output
   // combinational path.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      rdy_cnt_d  = rdy_cnt_q;
      data_d     = packet_data;
      op_d       = op_code;
      len_d      = packet_len;
      rdy_d      = packet_rdy;
      err_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // The held frame stays untouched until a new frame is opened.
            if (frame_start) begin
               data_d     = acc_data;
               count_d    = acc_count;
               overflow_d = acc_overflow;
               state_d    = ST_RECEIVE;
            end
         end

         ST_RECEIVE: begin
            data_d     = acc_data;
            count_d    = acc_count;
            overflow_d = acc_overflow;
            // A restart discards the partial frame silently; any frame_end
            // in the same cycle belongs to the abandoned frame.
            if (frame_end && !frame_start) begin
               if (acc_overflow || (acc_count < CLASS_BITS) ||
                   (acc_count < class_min_len(acc_class))) begin
                  err_d   = 1'b1;
                  op_d    = OPC_INVALID;
                  state_d = ST_IDLE;
               end else begin
                  op_d      = acc_class;
                  len_d     = acc_count;
                  rdy_d     = 1'b1;
                  rdy_cnt_d = RDY_LOAD;
                  state_d   = ST_PRESENT;
               end
            end
         end

         ST_PRESENT: begin
            if (rdy_cnt_q == '0) begin
               rdy_d   = 1'b0;
               state_d = ST_IDLE;
            end else begin
               rdy_cnt_d = rdy_cnt_q - RDY_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            rdy_d   = 1'b0;
         end
      endcase
   end

   // NOTE: state registers take non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         count_q     <= 8'd0;
         overflow_q  <= 1'b0;
         rdy_cnt_q   <= '0;
         packet_data <= '0;
         op_code     <= OPC_CMD2;
         packet_len  <= 8'd0;
         packet_rdy  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         rdy_cnt_q   <= rdy_cnt_d;
         packet_data <= data_d;
         op_code     <= op_d;
         packet_len  <= len_d;
         packet_rdy  <= rdy_d;
         frame_error <= err_d;
      end
   end

endmodule

// File: tb/tb_rfid_packet_assembler.sv
// ----------------------------------------------------------------------------
// tb_rfid_packet_assembler
//   Self-checking bench for rfid_packet_assembler: a table of directed frames,
//   hand-written multi-cycle sequences (restart, ignored start in PRESENT,
//   asynchronous reset) and randomized frames predicted by a frame-level model.
// ----------------------------------------------------------------------------
module tb_rfid_packet_assembler;
   import rfid_pkg::*;

   localparam int RDY = 2;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         frame_start = 1'b0;
   logic         bit_valid = 1'b0;
   logic         bit_data = 1'b0;
   logic         frame_end = 1'b0;
   logic [127:0] packet_data;
   logic [1:0]   op_code;
   logic [7:0]   packet_len;
   logic         packet_rdy;
   logic         frame_error;

   int vec_cnt = 0;
   int err_cnt = 0;

   rfid_packet_assembler #(.RDY_CYCLES(RDY), .MAX_BITS(128)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .frame_start (frame_start),
      .bit_valid   (bit_valid),
      .bit_data    (bit_data),
      .frame_end   (frame_end),
      .packet_data (packet_data),
      .op_code     (op_code),
      .packet_len  (packet_len),
      .packet_rdy  (packet_rdy),
      .frame_error (frame_error)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // Directed frame: pattern holds the first bit at index n-1.
   typedef struct {
      logic [159:0] pat;
      int           n;
      bit           exp_err;
      logic [1:0]   exp_op;
      logic [7:0]   exp_len;
   } vec_t;

   vec_t tbl[12];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      frame_start = 1'b0;
      bit_valid   = 1'b0;
      bit_data    = 1'b0;
      frame_end   = 1'b0;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Frame bits left-justified: first bit at [127], remaining bits zero.
   function automatic logic [127:0] ljust(input logic [159:0] pat, input int n);
      logic [127:0] r = '0;
      for (int i = 0; i < n && i < 128; i++) r[127-i] = pat[n-1-i];
      return r;
   endfunction

   // Frame-level reference: length/overflow and class rules from the first bits.
   task automatic ref_frame(input logic [159:0] pat, input int n,
                            output bit err, output logic [1:0] op, output logic [7:0] len);
      int min_len;
      op  = OPC_INVALID;
      len = 8'(n);
      err = 1'b0;
      if (n > 128 || n < 2) begin
         err = 1'b1;
      end else begin
         if (pat[n-1] == 1'b0)      begin op = OPC_CMD2; min_len = 2; end
         else if (pat[n-2] == 1'b0) begin op = OPC_CMD4; min_len = 4; end
         else                       begin op = OPC_CMD8; min_len = 8; end
         if (n < min_len) err = 1'b1;
      end
      if (err) op = OPC_INVALID;
   endtask

   // Drives frame_start, the n bits (optionally with idle gaps) and frame_end.
   // Returns #1 after the edge that sampled the end of the frame.
   task automatic drive_frame(input logic [159:0] pat, input int n,
                              input bit merge_start, input bit merge_end, input int gap_pct);
      int i = 0;
      bit ended = 1'b0;
      frame_start = 1'b1;
      if (merge_start && n > 0) begin
         bit_valid = 1'b1;
         bit_data  = pat[n-1];
         i = 1;
      end
      tick();
      idle_inputs();
      while (i < n) begin
         if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) tick();
         bit_valid = 1'b1;
         bit_data  = pat[n-1-i];
         if (i == n - 1 && merge_end) begin
            frame_end = 1'b1;
            ended = 1'b1;
         end
         tick();
         idle_inputs();
         i++;
      end
      if (!ended) begin
         frame_end = 1'b1;
         tick();
         idle_inputs();
      end
   endtask

   // Checks the outcome of a frame whose frame_end edge has just passed.
   task automatic expect_outcome(input string tag, input bit exp_err, input logic [1:0] exp_op,
                                 input logic [7:0] exp_len, input logic [127:0] exp_data);
      int hi;
      if (exp_err) begin
         check({tag, " frame_error"}, 128'(frame_error), 128'(1));
         check({tag, " packet_rdy low"}, 128'(packet_rdy), 128'(0));
         check({tag, " op_code invalid"}, 128'(op_code), 128'(OPC_INVALID));
         tick();
         check({tag, " frame_error one cycle"}, 128'(frame_error), 128'(0));
         check({tag, " packet_rdy stays low"}, 128'(packet_rdy), 128'(0));
      end else begin
         check({tag, " packet_rdy"}, 128'(packet_rdy), 128'(1));
         check({tag, " no frame_error"}, 128'(frame_error), 128'(0));
         check({tag, " op_code"}, 128'(op_code), 128'(exp_op));
         check({tag, " packet_len"}, 128'(packet_len), 128'(exp_len));
         check({tag, " packet_data"}, packet_data, exp_data);
         hi = 1;
         while (packet_rdy === 1'b1 && hi <= RDY + 4) begin
            tick();
            if (packet_rdy === 1'b1) hi++;
         end
         check({tag, " rdy cycles"}, 128'(hi), 128'(RDY));
         check({tag, " data held"}, packet_data, exp_data);
         check({tag, " op held"}, 128'(op_code), 128'(exp_op));
         check({tag, " len held"}, 128'(packet_len), 128'(exp_len));
      end
   endtask

   initial begin
      bit           r_err;
      logic [1:0]   r_op;
      logic [7:0]   r_len;
      logic [159:0] pat;
      int           n;
      int           sel;

      tbl[0]  = '{160'(4'b0001), 4, 1'b0, 2'd0, 8'd4};                        // QueryRep
      tbl[1]  = '{160'(22'b10000000_00000000_010000), 22, 1'b0, 2'd1, 8'd22}; // Query
      tbl[2]  = '{160'(8'b11000000), 8, 1'b0, 2'd2, 8'd8};                    // NAK
      tbl[3]  = '{160'(1'b1), 1, 1'b1, 2'd3, 8'd0};                           // 1-bit runt
      tbl[4]  = '{160'(3'b110), 3, 1'b1, 2'd3, 8'd0};                         // class 2 short
      tbl[5]  = '{160'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 130, 1'b1, 2'd3, 8'd0};
      tbl[6]  = '{160'(8'hC5), 8, 1'b0, 2'd2, 8'd8};                          // after overflow
      tbl[7]  = '{160'(2'b01), 2, 1'b0, 2'd0, 8'd2};                          // class 0 minimum
      tbl[8]  = '{160'(3'b101), 3, 1'b1, 2'd3, 8'd0};                         // class 1 short
      tbl[9]  = '{160'h00000000_A5C30F96_12345678_9ABCDEF0_0FF05AA5, 128, 1'b0, 2'd1, 8'd128};
      tbl[10] = '{160'(7'b1100000), 7, 1'b1, 2'd3, 8'd0};                     // class 2 one short
      tbl[11] = '{160'(0), 0, 1'b1, 2'd3, 8'd0};                              // empty frame

      // Reset values.
      idle_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      check("reset packet_data", packet_data, 128'(0));
      check("reset op_code", 128'(op_code), 128'(0));
      check("reset packet_len", 128'(packet_len), 128'(0));
      check("reset packet_rdy", 128'(packet_rdy), 128'(0));
      check("reset frame_error", 128'(frame_error), 128'(0));
      reset_n = 1'b1;
      tick();

      // frame_end and bits while IDLE are ignored.
      frame_end = 1'b1;
      bit_valid = 1'b1;
      bit_data  = 1'b1;
      tick();
      idle_inputs();
      check("idle frame_end no error", 128'(frame_error), 128'(0));
      check("idle frame_end no rdy", 128'(packet_rdy), 128'(0));
      check("idle bit ignored", packet_data, 128'(0));

      // Directed table.
      for (int v = 0; v < 12; v++) begin
         drive_frame(tbl[v].pat, tbl[v].n, 1'b0, 1'b0, 0);
         expect_outcome($sformatf("tbl%0d", v), tbl[v].exp_err, tbl[v].exp_op,
                        tbl[v].exp_len, ljust(tbl[v].pat, tbl[v].n));
         tick();
      end

      // frame_start (with a bit and frame_end) during PRESENT is ignored.
      drive_frame(160'(8'b11000000), 8, 1'b0, 1'b0, 0);
      check("nak rdy", 128'(packet_rdy), 128'(1));
      check("nak op", 128'(op_code), 128'(OPC_CMD8));
      frame_start = 1'b1;
      bit_valid   = 1'b1;
      bit_data    = 1'b1;
      tick();
      idle_inputs();
      check("present start ignored rdy", 128'(packet_rdy), 128'(1));
      check("present start ignored data", packet_data, 128'(8'b11000000) << 120);
      check("present start ignored len", 128'(packet_len), 128'(8));
      tick();
      check("present rdy fall", 128'(packet_rdy), 128'(0));
      frame_end = 1'b1;
      tick();
      idle_inputs();
      check("present start not taken", 128'(frame_error), 128'(0));
      check("present data after fall", packet_data, 128'(8'b11000000) << 120);

      // Restart in RECEIVE: partial frame dropped silently, coincident bit is bit 0.
      frame_start = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         bit_valid = 1'b1;
         bit_data  = 1'b1;
         tick();
      end
      idle_inputs();
      frame_start = 1'b1;
      bit_valid   = 1'b1;
      bit_data    = 1'b0;
      tick();
      idle_inputs();
      check("restart no error", 128'(frame_error), 128'(0));
      check("restart no rdy", 128'(packet_rdy), 128'(0));
      bit_valid = 1'b1; bit_data = 1'b0; tick();
      bit_valid = 1'b1; bit_data = 1'b0; tick();
      bit_valid = 1'b1; bit_data = 1'b1; frame_end = 1'b1; tick();
      idle_inputs();
      expect_outcome("restart", 1'b0, OPC_CMD2, 8'd4, 128'(4'b0001) << 124);
      tick();

      // Asynchronous reset after 5 bits.
      frame_start = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         idle_inputs();
         bit_valid = 1'b1;
         bit_data  = 1'b1;
         tick();
      end
      idle_inputs();
      #2;
      reset_n = 1'b0;
      #1;
      check("midreset packet_data", packet_data, 128'(0));
      check("midreset op_code", 128'(op_code), 128'(0));
      check("midreset packet_len", 128'(packet_len), 128'(0));
      check("midreset packet_rdy", 128'(packet_rdy), 128'(0));
      check("midreset frame_error", 128'(frame_error), 128'(0));
      tick();
      reset_n = 1'b1;
      tick();
      check("postreset no error", 128'(frame_error), 128'(0));
      drive_frame(160'(8'b10110011), 8, 1'b0, 1'b0, 0);
      expect_outcome("postreset", 1'b0, OPC_CMD4, 8'd8, 128'(8'b10110011) << 120);
      tick();

      // Randomized frames against the frame-level model.
      for (int f = 0; f < 60; f++) begin
         sel = int'($urandom_range(9));
         if (sel < 6)      n = int'($urandom_range(12));
         else if (sel < 9) n = int'($urandom_range(40));
         else              n = int'($urandom_range(140, 124));
         pat = {$urandom, $urandom, $urandom, $urandom, $urandom};
         ref_frame(pat, n, r_err, r_op, r_len);
         drive_frame(pat, n, 1'($urandom_range(1)), 1'($urandom_range(1)), 20);
         expect_outcome($sformatf("rand%0d n=%0d", f, n), r_err, r_op, r_len, ljust(pat, n));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
